// File: rtl/psum_pkg.sv
// Shared definitions for the ping-pong partial-sum accumulator: default sizes,
// fill-FSM state encoding and the saturating/wrapping adder.
package psum_pkg;

    localparam int PSUM_WIDTH_DEF = 24;
    localparam int LENROW_DEF     = 16;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITIN = 2'd1,
        WRITE  = 2'd2,
        HOLD   = 2'd3
    } fill_state_e;

    // Adds two sign-extended operands and folds the result back to a w-bit
    // signed range: clamp when sat is set, two's-complement wrap otherwise.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w,
        input bit                 sat
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        return (s <<< (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/psum_pp_acc_if.sv
// Bundle of the fill, MAC-write and drain handshakes of the partial-sum accumulator.
interface psum_pp_acc_if #(
    parameter int PSUM_WIDTH = 24,
    parameter int LENROW     = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_PORT   = 2
);
    logic                                        arb_fnh;
    logic                                        mac_empty;
    logic                                        psum_empty;
    logic                                        datain_val;
    logic [PSUM_WIDTH*LENROW-1:0]                datain;
    logic                                        datain_rdy;
    logic [NUM_PORT-1:0]                         psumaddr_val;
    logic [NUM_PORT*(ADDR_WIDTH+PSUM_WIDTH)-1:0] psumaddr;
    logic [NUM_PORT-1:0]                         psumaddr_rdy;
    logic                                        dataout_val;
    logic [PSUM_WIDTH*LENROW-1:0]                dataout;
    logic                                        dataout_rdy;

    modport master (
        output arb_fnh, mac_empty, datain_val, datain, psumaddr_val, psumaddr, dataout_rdy,
        input  psum_empty, datain_rdy, psumaddr_rdy, dataout_val, dataout
    );

    modport slave (
        input  arb_fnh, mac_empty, datain_val, datain, psumaddr_val, psumaddr, dataout_rdy,
        output psum_empty, datain_rdy, psumaddr_rdy, dataout_val, dataout
    );
endinterface

// File: rtl/psum_lane_acc.sv
// One lane of the accumulator: gathers every port hitting this lane and adds
// them to the current value in a single cycle, then saturates or wraps.
module psum_lane_acc
    import psum_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORT   = 2,
    parameter int SAT_EN     = 1
) (
    input  logic [ADDR_WIDTH-1:0]                lane,
    input  logic [NUM_PORT-1:0]                  val,
    input  logic [NUM_PORT-1:0][ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORT-1:0][PSUM_WIDTH-1:0]  data,
    input  logic signed [PSUM_WIDTH-1:0]         cur,
    output logic signed [PSUM_WIDTH-1:0]         nxt
);
    // Wide enough that NUM_PORT colliding operands can never overflow.
    localparam int SUM_W = PSUM_WIDTH + $clog2(NUM_PORT + 1);

    logic signed [SUM_W-1:0] port_sum;

    always_comb begin
        port_sum = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (val[p] && (addr[p] == lane)) begin
                port_sum = port_sum + SUM_W'(signed'(data[p]));
            end
        end
        nxt = PSUM_WIDTH'(sat_add(64'(cur), 64'(port_sum), PSUM_WIDTH, SAT_EN != 0));
    end

endmodule

// File: rtl/psum_pp_acc.sv
// Ping-pong partial-sum accumulator: one bank is preloaded and accumulated from
// NUM_PORT MAC streams while the other, completed bank drains to GB.
module psum_pp_acc
    import psum_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int LENROW     = LENROW_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORT   = 2,
    parameter int SAT_EN     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reset,
    psum_pp_acc_if.slave bus
);
    localparam int PORT_W = ADDR_WIDTH + PSUM_WIDTH;

    fill_state_e state;
    fill_state_e state_nxt;

    logic                          fill_ptr;
    logic                          drain_ptr;
    logic [1:0]                    bank_vld;
    logic signed [PSUM_WIDTH-1:0]  bank [2][LENROW];
    logic signed [PSUM_WIDTH-1:0]  lane_nxt [LENROW];

    logic [NUM_PORT-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORT-1:0][PSUM_WIDTH-1:0] port_data;

    logic write_fnh;
    logic drain_fire;
    logic drain_free;
    logic swap;
    logic preload;
    logic acc_en;

    assign drain_ptr  = ~fill_ptr;
    assign write_fnh  = bus.mac_empty & ~(|bus.psumaddr_val);
    assign drain_fire = bus.dataout_val & bus.dataout_rdy;
    // A bank being handed to GB this very cycle counts as free, so a finishing
    // row can swap in without a bubble.
    assign drain_free = ~bank_vld[drain_ptr] | drain_fire;
    assign swap       = ~reset & drain_free &
                        (((state == WRITE) & write_fnh & bus.arb_fnh) | (state == HOLD));
    assign preload    = (state == WAITIN) & bus.datain_val;
    assign acc_en     = (state == WRITE);

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            port_addr[p] = bus.psumaddr[p*PORT_W +: ADDR_WIDTH];
            port_data[p] = bus.psumaddr[p*PORT_W + ADDR_WIDTH +: PSUM_WIDTH];
        end
    end

    for (genvar l = 0; l < LENROW; l++) begin : g_lane
        psum_lane_acc #(
            .PSUM_WIDTH (PSUM_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_PORT   (NUM_PORT),
            .SAT_EN     (SAT_EN)
        ) u_lane (
            .lane (ADDR_WIDTH'(l)),
            .val  (bus.psumaddr_val),
            .addr (port_addr),
            .data (port_data),
            .cur  (bank[fill_ptr][l]),
            .nxt  (lane_nxt[l])
        );
    end

    // Fill FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.arb_fnh)   state_nxt = WAITIN;
            WAITIN:  if (bus.datain_val) state_nxt = WRITE;
            WRITE:   if (write_fnh && bus.arb_fnh) state_nxt = drain_free ? IDLE : HOLD;
            HOLD:    if (drain_free)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill FSM: outputs
    always_comb begin
        bus.psum_empty   = (state == IDLE);
        bus.datain_rdy   = (state == WAITIN);
        bus.psumaddr_rdy = {NUM_PORT{state == WRITE}};
    end

    // Ping-pong control: drain invalidates its bank, swap publishes the fill bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_vld <= '0;
            fill_ptr <= 1'b0;
        end else if (reset) begin
            bank_vld <= '0;
        end else begin
            if (drain_fire) bank_vld[drain_ptr] <= 1'b0;
            if (swap) begin
                bank_vld[fill_ptr] <= 1'b1;
                fill_ptr           <= ~fill_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < LENROW; l++) begin
                    bank[b][l] <= '0;
                end
            end
        end else if (!reset) begin
            if (preload) begin
                for (int l = 0; l < LENROW; l++) begin
                    bank[fill_ptr][l] <= bus.datain[l*PSUM_WIDTH +: PSUM_WIDTH];
                end
            end else if (acc_en) begin
                for (int l = 0; l < LENROW; l++) begin
                    bank[fill_ptr][l] <= lane_nxt[l];
                end
            end
        end
    end

    assign bus.dataout_val = bank_vld[drain_ptr];

    always_comb begin
        for (int l = 0; l < LENROW; l++) begin
            bus.dataout[l*PSUM_WIDTH +: PSUM_WIDTH] = bank[drain_ptr][l];
        end
    end

endmodule
